fetch_stage: RTL

Instruction-fetch stage of the WISC-SP13 pipeline; the producing end of the instruction interface that decode consumes (Instr, PCInc) and the consuming end of decode's redirect outputs (PCsel, BJAddr, Halt). Holds the PC and drives a variable-latency instruction-memory request/done handshake. Registers the fetched word into the IF/ID output register and absorbs decode stalls with a one-entry skid buffer. Handles branch/jump redirect squash, halt and memory error.

---
 rtl/fetch_stage_pkg.sv | 16 +
 rtl/fetch_stage_if.sv | 28 ++
 rtl/fetch_pc_reg.sv | 26 ++
 rtl/fetch_stage.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the WISC-SP13 instruction-fetch stage:
// FSM state encoding and fixed instruction/PC constants.
package fetch_stage_pkg;

  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_SKID   = 2'd1,
    S_FLUSH  = 2'd2,
    S_HALTED = 2'd3
  } fetch_state_e;

  localparam logic [15:0] NOP_WORD    = 16'h0800;
  localparam logic [4:0]  HALT_OPCODE = 5'b00000;
  localparam logic [15:0] PC_STEP     = 16'd2;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory handshake plus the IF/ID and redirect signals shared with decode.
// master = fetch stage, slave = memory/decode side.
interface fetch_stage_if;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] imem_rd_data;
  logic        imem_done;
  logic        imem_err;

  logic        pc_sel;
  logic [15:0] bj_addr;
  logic        halt;
  logic        stall;

  logic [15:0] instr;
  logic [15:0] pc_inc;
  logic        valid;

  modport master (
    output imem_req, imem_addr, instr, pc_inc, valid,
    input  imem_rd_data, imem_done, imem_err, pc_sel, bj_addr, halt, stall
  );

  modport slave (
    input  imem_req, imem_addr, instr, pc_inc, valid,
    output imem_rd_data, imem_done, imem_err, pc_sel, bj_addr, halt, stall
  );
endinterface

// File: rtl/fetch_pc_reg.sv
// 16-bit program counter: redirect load has priority over the sequential step;
// the increment wraps modulo 2^16.
module fetch_pc_reg
  import fetch_stage_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] target,
  input  logic        step,
  output logic [15:0] pc,
  output logic [15:0] pc_next
);

  assign pc_next = pc + PC_STEP;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      pc <= RESET_PC;
    else if (load) pc <= target;
    else if (step) pc <= pc_next;
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, variable-latency imem handshake, IF/ID register
// with a one-entry skid buffer, redirect squash, halt and sticky fetch error.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = NOP_WORD
) (
  input  logic          clk,
  input  logic          rst,
  fetch_stage_if.master bus,
  output logic          halted,
  output logic          err
);

  fetch_state_e state, state_next;

  logic [15:0] pc, pc_next, flush_addr;
  logic [15:0] instr_q, pc_inc_q, skid_instr, skid_pc_inc;
  logic        valid_q;
  logic        consume, free;
  logic        pc_load, pc_step, ifid_load_mem, ifid_load_skid, ifid_clear;
  logic        skid_load, flush_cap, err_set;

  assign consume = valid_q & ~bus.stall;
  assign free    = ~valid_q | ~bus.stall;

  fetch_pc_reg #(.RESET_PC(RESET_PC)) u_pc (
    .clk     (clk),
    .rst     (rst),
    .load    (pc_load),
    .target  (bus.bj_addr),
    .step    (pc_step),
    .pc      (pc),
    .pc_next (pc_next)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_FETCH;
    else      state <= state_next;
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_next     = state;
    pc_load        = 1'b0;
    pc_step        = 1'b0;
    ifid_load_mem  = 1'b0;
    ifid_load_skid = 1'b0;
    ifid_clear     = 1'b0;
    skid_load      = 1'b0;
    flush_cap      = 1'b0;
    err_set        = 1'b0;
    if (state != S_HALTED) begin
      if (bus.pc_sel) begin
        // The redirect squashes any younger halt and any data returned this cycle.
        pc_load    = 1'b1;
        ifid_clear = 1'b1;
        if ((state == S_FETCH || state == S_FLUSH) && !bus.imem_done) begin
          state_next = S_FLUSH;
          flush_cap  = (state == S_FETCH);
        end else begin
          state_next = S_FETCH;
        end
      end else if (bus.halt) begin
        state_next = S_HALTED;
        ifid_clear = 1'b1;
      end else begin
        case (state)
          S_FETCH: begin
            if (bus.imem_done && bus.imem_err) begin
              err_set    = 1'b1;
              ifid_clear = 1'b1;
              state_next = S_HALTED;
            end else if (bus.imem_done) begin
              pc_step = 1'b1;
              if (free) begin
                ifid_load_mem = 1'b1;
              end else begin
                skid_load  = 1'b1;
                state_next = S_SKID;
              end
            end else if (consume) begin
              ifid_clear = 1'b1;
            end
          end
          S_SKID: begin
            if (consume) begin
              ifid_load_skid = 1'b1;
              state_next     = S_FETCH;
            end
          end
          S_FLUSH: begin
            if (bus.imem_done) state_next = S_FETCH;
            if (consume)       ifid_clear = 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q     <= 1'b0;
      instr_q     <= NOP_INSTR;
      pc_inc_q    <= 16'h0000;
      skid_instr  <= NOP_INSTR;
      skid_pc_inc <= 16'h0000;
      flush_addr  <= RESET_PC;
      err         <= 1'b0;
    end else begin
      if (ifid_clear) begin
        valid_q <= 1'b0;
      end else if (ifid_load_mem) begin
        valid_q  <= 1'b1;
        instr_q  <= bus.imem_rd_data;
        pc_inc_q <= pc_next;
      end else if (ifid_load_skid) begin
        valid_q  <= 1'b1;
        instr_q  <= skid_instr;
        pc_inc_q <= skid_pc_inc;
      end
      if (skid_load) begin
        skid_instr  <= bus.imem_rd_data;
        skid_pc_inc <= pc_next;
      end
      if (flush_cap) flush_addr <= pc;
      if (err_set)   err        <= 1'b1;
    end
  end

  // The squashed request keeps its original address while the PC already holds the target.
  assign bus.imem_req  = rst && (state == S_FETCH || state == S_FLUSH);
  assign bus.imem_addr = (state == S_FLUSH) ? flush_addr : pc;
  assign bus.instr     = valid_q ? instr_q : NOP_INSTR;
  assign bus.pc_inc    = pc_inc_q;
  assign bus.valid     = valid_q;
  assign halted        = (state == S_HALTED);

endmodule
